gc_refresh_sequencer: RTL and testbench

Initiator side of the gain-cell DRAM refresh-tracking interface. A retention timer schedules refresh passes; each pass first clears the per-row refresh tracker, then sweeps all rows. For each row it queries the tracker and performs a read/write-back refresh only if the row has not already been refreshed by a user access. The block sits between the refresh tracker, the user-access arbiter and the memory array port.

---
 rtl/gc_refresh_pkg.sv | 18 +
 rtl/gc_refresh_sequencer_if.sv | 28 ++
 rtl/gc_retention_timer.sv | 30 +++
 rtl/gc_refresh_sequencer.sv | 134 +++++++++++++
 tb/tb_gc_refresh_sequencer.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/gc_refresh_pkg.sv
// Shared types and default widths for the gain-cell refresh sequencer slice.
package gc_refresh_pkg;

  localparam int unsigned DEF_ADDR_W = 7;
  localparam int unsigned DEF_ROWS   = 128;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned PASS_CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_CHECK,
    ST_WAIT,
    ST_WRITE,
    ST_NEXT
  } refresh_state_t;

endpackage

// File: rtl/gc_refresh_sequencer_if.sv
// Tracker and array-port signals shared by the refresh sequencer and its neighbours.
interface gc_refresh_sequencer_if #(
  parameter int unsigned ADDR_W = gc_refresh_pkg::DEF_ADDR_W,
  parameter int unsigned DATA_W = gc_refresh_pkg::DEF_DATA_W
);

  logic              trk_start;
  logic [ADDR_W-1:0] chk_addr;
  logic              chk_fresh;
  logic              ref_mark;
  logic              user_busy;
  logic              mem_re;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output trk_start, chk_addr, ref_mark, mem_re, mem_we, mem_addr, mem_wdata,
    input  chk_fresh, user_busy, mem_rdata
  );

  modport slave (
    input  trk_start, chk_addr, ref_mark, mem_re, mem_we, mem_addr, mem_wdata,
    output chk_fresh, user_busy, mem_rdata
  );

endinterface

// File: rtl/gc_retention_timer.sv
// Retention timer: counts enabled cycles and pulses when the deadline value is reached.
module gc_retention_timer #(
  parameter int unsigned RETENTION_CYCLES = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  output logic deadline_c
);

  localparam int unsigned TIMER_W = (RETENTION_CYCLES > 2) ? $clog2(RETENTION_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] LAST = TIMER_W'(RETENTION_CYCLES - 1);

  logic [TIMER_W-1:0] count;

  assign deadline_c = enable && !clear && (count == LAST);

  // Wraps on the deadline so an overrunning pass still sees the next deadline on time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear || deadline_c) begin
      count <= '0;
    end else if (enable) begin
      count <= count + TIMER_W'(1);
    end
  end

endmodule

// File: rtl/gc_refresh_sequencer.sv
// Refresh initiator: clears the tracker each pass, then read/write-back refreshes every stale row.
module gc_refresh_sequencer
  import gc_refresh_pkg::*;
#(
  parameter int unsigned ADDR_W           = DEF_ADDR_W,
  parameter int unsigned ROWS             = DEF_ROWS,
  parameter int unsigned DATA_W           = DEF_DATA_W,
  parameter int unsigned RETENTION_CYCLES = 4096,
  parameter int unsigned READ_LAT         = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  force_refresh,
  gc_refresh_sequencer_if.master bus,
  output logic                  busy,
  output logic [PASS_CNT_W-1:0] pass_count,
  output logic                  overrun
);

  localparam int unsigned LAT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  refresh_state_t    state;
  refresh_state_t    state_next;
  logic [ADDR_W-1:0] row;
  logic [DATA_W-1:0] data;
  logic [LAT_W-1:0]  lat_cnt;
  logic              pending;
  logic              deadline_c;

  logic in_pass_c;
  logic last_row_c;
  logic lat_done_c;
  logic trigger_c;

  assign in_pass_c  = (state != ST_IDLE);
  assign last_row_c = (row == ADDR_W'(ROWS - 1));
  assign lat_done_c = (lat_cnt == LAT_W'(READ_LAT - 1));
  assign trigger_c  = deadline_c || force_refresh || pending;

  gc_retention_timer #(
    .RETENTION_CYCLES(RETENTION_CYCLES)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .clear     (state == ST_START),
    .deadline_c(deadline_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (trigger_c) state_next = ST_START;
      ST_START: state_next = ST_CHECK;
      ST_CHECK: begin
        if (bus.chk_fresh)      state_next = ST_NEXT;
        else if (!bus.user_busy) state_next = ST_WAIT;
      end
      ST_WAIT:  if (lat_done_c) state_next = ST_WRITE;
      ST_WRITE: if (!bus.user_busy) state_next = ST_NEXT;
      ST_NEXT:  state_next = last_row_c ? ST_IDLE : ST_CHECK;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Array and tracker strobes are decoded so they can yield to user_busy in the same cycle.
  always_comb begin
    bus.chk_addr  = '0;
    bus.ref_mark  = 1'b0;
    bus.mem_re    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    case (state)
      ST_CHECK: begin
        bus.chk_addr = row;
        if (!bus.chk_fresh && !bus.user_busy) begin
          bus.mem_re   = 1'b1;
          bus.mem_addr = row;
        end
      end
      ST_WRITE: begin
        bus.chk_addr = row;
        if (!bus.user_busy) begin
          bus.mem_we    = 1'b1;
          bus.mem_addr  = row;
          bus.mem_wdata = data;
          bus.ref_mark  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Row/data datapath, request flags and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row           <= '0;
      data          <= '0;
      lat_cnt       <= '0;
      pending       <= 1'b0;
      overrun       <= 1'b0;
      pass_count    <= '0;
      busy          <= 1'b0;
      bus.trk_start <= 1'b0;
    end else begin
      bus.trk_start <= (state_next == ST_START);
      busy          <= (state_next != ST_IDLE);
      if (in_pass_c && deadline_c) overrun <= 1'b1;
      if (in_pass_c && (deadline_c || force_refresh)) pending <= 1'b1;
      else if (state == ST_START)                     pending <= 1'b0;
      case (state)
        ST_START: row <= '0;
        ST_CHECK: lat_cnt <= '0;
        ST_WAIT: begin
          if (lat_done_c) data <= bus.mem_rdata;
          else            lat_cnt <= lat_cnt + LAT_W'(1);
        end
        ST_NEXT: begin
          if (last_row_c) pass_count <= pass_count + PASS_CNT_W'(1);
          else            row <= row + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gc_refresh_sequencer.sv
// Directed bench for gc_refresh_sequencer: one DUT at RETENTION_CYCLES=600, one at 300.
module tb_gc_refresh_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_en = 1'b0, a_force = 1'b0, b_en = 1'b0;
  logic        a_busy, a_ovr, b_busy, b_ovr;
  logic [15:0] a_pc, b_pc;
  logic [127:0] skip_mask = '0;
  int          cyc = 0;
  int          n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gc_refresh_sequencer_if #(.ADDR_W(7), .DATA_W(32)) a_bus ();
  gc_refresh_sequencer_if #(.ADDR_W(7), .DATA_W(32)) b_bus ();

  gc_refresh_sequencer #(.RETENTION_CYCLES(600), .READ_LAT(1)) dut_a (
    .clk(clk), .rst(rst), .enable(a_en), .force_refresh(a_force), .bus(a_bus),
    .busy(a_busy), .pass_count(a_pc), .overrun(a_ovr)
  );

  gc_refresh_sequencer #(.RETENTION_CYCLES(300), .READ_LAT(1)) dut_b (
    .clk(clk), .rst(rst), .enable(b_en), .force_refresh(1'b0), .bus(b_bus),
    .busy(b_busy), .pass_count(b_pc), .overrun(b_ovr)
  );

  function automatic logic [31:0] pat(input logic [6:0] a);
    pat = {8'hA5, ~{1'b0, a}, 8'h3C, {1'b0, a}};
  endfunction

  // Tracker and one-cycle-latency array models; rdata is poisoned when no read was issued.
  assign a_bus.chk_fresh = skip_mask[a_bus.chk_addr];
  assign b_bus.chk_fresh = 1'b0;
  assign b_bus.user_busy = 1'b0;
  always @(posedge clk) a_bus.mem_rdata <= a_bus.mem_re ? pat(a_bus.mem_addr) : 32'hDEAD_BEEF;
  always @(posedge clk) b_bus.mem_rdata <= b_bus.mem_re ? pat(b_bus.mem_addr) : 32'hDEAD_BEEF;

  int trk_n, re_n, we_n, ref_n, wd_err, ord_err, viol, rise, plen, last_re;
  int trk_cyc[4];
  int rd_cnt[128], wr_cnt[128], re_cyc[128], we_cyc[128];
  logic prev_busy;
  bit   have_prev;

  always @(negedge clk) begin
    if (rst) begin
      trk_n = 0; re_n = 0; we_n = 0; ref_n = 0; wd_err = 0; ord_err = 0; viol = 0;
      rise = -1; plen = -1; last_re = -1; prev_busy = 1'b0; have_prev = 1'b0;
      for (int i = 0; i < 4; i++) trk_cyc[i] = -1;
      for (int i = 0; i < 128; i++) begin
        rd_cnt[i] = 0; wr_cnt[i] = 0; re_cyc[i] = -1; we_cyc[i] = -1;
      end
    end else begin
      if (a_bus.trk_start) begin
        if (trk_n < 4) trk_cyc[trk_n] = cyc;
        trk_n++;
        have_prev = 1'b0;
      end
      if (a_bus.mem_re) begin
        if (have_prev && int'(a_bus.mem_addr) <= last_re) ord_err++;
        last_re = int'(a_bus.mem_addr);
        have_prev = 1'b1;
        re_n++;
        rd_cnt[a_bus.mem_addr]++;
        re_cyc[a_bus.mem_addr] = cyc;
      end
      if (a_bus.mem_we) begin
        we_n++;
        wr_cnt[a_bus.mem_addr]++;
        we_cyc[a_bus.mem_addr] = cyc;
        if (a_bus.mem_wdata !== pat(a_bus.mem_addr)) wd_err++;
        if (int'(a_bus.mem_addr) != last_re) ord_err++;
      end
      if (a_bus.ref_mark) ref_n++;
      if (a_bus.ref_mark !== a_bus.mem_we) viol++;
      if (a_bus.ref_mark && a_bus.chk_addr !== a_bus.mem_addr) viol++;
      if ((a_bus.mem_re || a_bus.mem_we) && a_bus.user_busy) viol++;
      if (a_bus.mem_re && a_bus.mem_we) viol++;
      if (a_busy && !prev_busy) rise = cyc;
      if (!a_busy && prev_busy) plen = cyc - rise;
      prev_busy = a_busy;
    end
  end

  int b_trk_n, b_ovr_cyc;
  int b_trk_cyc[4];

  always @(negedge clk) begin
    if (rst) begin
      b_trk_n = 0; b_ovr_cyc = -1;
      for (int i = 0; i < 4; i++) b_trk_cyc[i] = -1;
    end else begin
      if (b_bus.trk_start) begin
        if (b_trk_n < 4) b_trk_cyc[b_trk_n] = cyc;
        b_trk_n++;
      end
      if (b_ovr && b_ovr_cyc < 0) b_ovr_cyc = cyc;
    end
  end

  task automatic wait_until(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; a_en = 1'b0; b_en = 1'b0; a_force = 1'b0;
    a_bus.user_busy = 1'b0; skip_mask = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic pulse_force();
    a_force = 1'b1;
    @(posedge clk);
    #1 a_force = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; a_bus.user_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if ({a_busy, a_bus.trk_start, a_ovr, a_bus.mem_re, a_bus.mem_we, a_bus.ref_mark} !== 6'b0)
      $display("FAIL reset_flags: got %b expected 000000", {a_busy, a_bus.trk_start, a_ovr, a_bus.mem_re, a_bus.mem_we, a_bus.ref_mark}); else n_pass++;
    n_chk++; if (a_pc !== 16'd0) $display("FAIL reset_pass_count: got %0d expected 0", a_pc); else n_pass++;
    n_chk++; if ({a_bus.chk_addr, a_bus.mem_addr} !== 14'd0) $display("FAIL reset_addr: got %h expected 0", {a_bus.chk_addr, a_bus.mem_addr}); else n_pass++;
    n_chk++; if (a_bus.mem_wdata !== 32'd0) $display("FAIL reset_wdata: got %h expected 0", a_bus.mem_wdata); else n_pass++;
  endtask

  task automatic test_basic_pass();
    int c0, s;
    do_reset();
    a_en = 1'b1;
    c0 = cyc;
    // Timer reads 599 in cycle c0+599; trk_start follows one cycle later.
    s = c0 + 600;
    wait_until(s + 520);
    n_chk++; if (trk_cyc[0] !== s) $display("FAIL basic_trk_start: got %0d expected %0d", trk_cyc[0], s); else n_pass++;
    n_chk++; if (plen !== 513) $display("FAIL basic_pass_len: got %0d expected 513", plen); else n_pass++;
    n_chk++; if (re_n !== 128) $display("FAIL basic_reads: got %0d expected 128", re_n); else n_pass++;
    n_chk++; if (we_n !== 128) $display("FAIL basic_writes: got %0d expected 128", we_n); else n_pass++;
    n_chk++; if (wd_err !== 0) $display("FAIL basic_wdata: got %0d errors expected 0", wd_err); else n_pass++;
    n_chk++; if (ord_err !== 0) $display("FAIL basic_order: got %0d errors expected 0", ord_err); else n_pass++;
    n_chk++; if (re_cyc[0] !== s + 1) $display("FAIL basic_first_read: got %0d expected %0d", re_cyc[0], s + 1); else n_pass++;
    n_chk++; if (we_cyc[127] !== s + 511) $display("FAIL basic_last_write: got %0d expected %0d", we_cyc[127], s + 511); else n_pass++;
    n_chk++; if (a_pc !== 16'd1) $display("FAIL basic_pass_count: got %0d expected 1", a_pc); else n_pass++;
    n_chk++; if (viol !== 0 || a_ovr !== 1'b0) $display("FAIL basic_protocol: got viol=%0d overrun=%b expected 0/0", viol, a_ovr); else n_pass++;
  endtask

  task automatic test_skip_rows();
    int s;
    do_reset();
    skip_mask[5] = 1'b1;
    skip_mask[100] = 1'b1;
    wait_until(cyc + 2);
    s = cyc + 1;
    pulse_force();
    wait_until(s + 520);
    n_chk++; if (trk_cyc[0] !== s) $display("FAIL skip_trk_start: got %0d expected %0d", trk_cyc[0], s); else n_pass++;
    n_chk++; if (plen !== 509) $display("FAIL skip_pass_len: got %0d expected 509", plen); else n_pass++;
    n_chk++; if (rd_cnt[5] + rd_cnt[100] !== 0) $display("FAIL skip_reads_5_100: got %0d expected 0", rd_cnt[5] + rd_cnt[100]); else n_pass++;
    n_chk++; if (wr_cnt[5] + wr_cnt[100] !== 0) $display("FAIL skip_writes_5_100: got %0d expected 0", wr_cnt[5] + wr_cnt[100]); else n_pass++;
    n_chk++; if (re_n !== 126 || we_n !== 126) $display("FAIL skip_counts: got re=%0d we=%0d expected 126/126", re_n, we_n); else n_pass++;
    n_chk++; if (re_cyc[6] !== s + 23) $display("FAIL skip_row6_read: got %0d expected %0d", re_cyc[6], s + 23); else n_pass++;
    n_chk++; if (a_pc !== 16'd1) $display("FAIL skip_pass_count: got %0d expected 1", a_pc); else n_pass++;
    n_chk++; if (wd_err !== 0 || ord_err !== 0) $display("FAIL skip_data: got wd=%0d ord=%0d expected 0/0", wd_err, ord_err); else n_pass++;
  endtask

  task automatic test_contention();
    int s;
    do_reset();
    wait_until(cyc + 2);
    s = cyc + 1;
    pulse_force();
    // Row 3 CHECK starts at s+13, row 7 WRITE at s+41 once shifted by the first stall.
    wait_until(s + 13); a_bus.user_busy = 1'b1;
    wait_until(s + 23); a_bus.user_busy = 1'b0;
    wait_until(s + 41); a_bus.user_busy = 1'b1;
    wait_until(s + 46); a_bus.user_busy = 1'b0;
    wait_until(s + 540);
    n_chk++; if (re_cyc[3] !== s + 23) $display("FAIL cont_row3_read: got %0d expected %0d", re_cyc[3], s + 23); else n_pass++;
    n_chk++; if (we_cyc[3] !== s + 25) $display("FAIL cont_row3_write: got %0d expected %0d", we_cyc[3], s + 25); else n_pass++;
    n_chk++; if (we_cyc[7] !== s + 46) $display("FAIL cont_row7_write: got %0d expected %0d", we_cyc[7], s + 46); else n_pass++;
    n_chk++; if (plen !== 528) $display("FAIL cont_pass_len: got %0d expected 528", plen); else n_pass++;
    n_chk++; if (viol !== 0) $display("FAIL cont_protocol: got %0d violations expected 0", viol); else n_pass++;
    n_chk++; if (wd_err !== 0 || we_n !== 128) $display("FAIL cont_data: got wd=%0d we=%0d expected 0/128", wd_err, we_n); else n_pass++;
  endtask

  task automatic test_force_refresh();
    int s;
    do_reset();
    wait_until(cyc + 3);
    s = cyc + 1;
    pulse_force();
    wait_until(s + 100);
    pulse_force();
    wait_until(s + 104);
    pulse_force();
    wait_until(s + 1050);
    n_chk++; if (trk_cyc[0] !== s) $display("FAIL force_first_start: got %0d expected %0d", trk_cyc[0], s); else n_pass++;
    n_chk++; if (trk_cyc[1] !== s + 514) $display("FAIL force_second_start: got %0d expected %0d", trk_cyc[1], s + 514); else n_pass++;
    n_chk++; if (trk_n !== 2) $display("FAIL force_pass_total: got %0d expected 2", trk_n); else n_pass++;
    n_chk++; if (a_pc !== 16'd2) $display("FAIL force_pass_count: got %0d expected 2", a_pc); else n_pass++;
    n_chk++; if (a_ovr !== 1'b0 || a_busy !== 1'b0) $display("FAIL force_idle: got ovr=%b busy=%b expected 0/0", a_ovr, a_busy); else n_pass++;
  endtask

  task automatic test_overrun();
    int p;
    do_reset();
    b_en = 1'b1;
    p = cyc + 300;
    wait_until(p + 300);
    n_chk++; if (b_ovr !== 1'b0) $display("FAIL ovr_early: got %b expected 0", b_ovr); else n_pass++;
    wait_until(p + 520);
    n_chk++; if (b_trk_cyc[0] !== p) $display("FAIL ovr_first_start: got %0d expected %0d", b_trk_cyc[0], p); else n_pass++;
    n_chk++; if (b_ovr_cyc !== p + 301) $display("FAIL ovr_set_cycle: got %0d expected %0d", b_ovr_cyc, p + 301); else n_pass++;
    n_chk++; if (b_trk_cyc[1] !== p + 514) $display("FAIL ovr_second_start: got %0d expected %0d", b_trk_cyc[1], p + 514); else n_pass++;
    n_chk++; if (b_pc !== 16'd1 || b_ovr !== 1'b1 || b_busy !== 1'b1) $display("FAIL ovr_state: got pc=%0d ovr=%b busy=%b expected 1/1/1", b_pc, b_ovr, b_busy); else n_pass++;
  endtask

  task automatic test_reset_mid_pass();
    int s;
    do_reset();
    wait_until(cyc + 2);
    s = cyc + 1;
    pulse_force();
    wait_until(s + 162);
    n_chk++; if (re_cyc[40] !== s + 161) $display("FAIL rmid_row40_read: got %0d expected %0d", re_cyc[40], s + 161); else n_pass++;
    n_chk++; if (ref_n !== 40 || wr_cnt[40] !== 0) $display("FAIL rmid_marks: got ref=%0d row40=%0d expected 40/0", ref_n, wr_cnt[40]); else n_pass++;
    rst = 1'b1;
    #1;
    n_chk++; if ({a_busy, a_bus.trk_start, a_ovr, a_bus.mem_re, a_bus.mem_we, a_bus.ref_mark} !== 6'b0)
      $display("FAIL rmid_flags: got %b expected 000000", {a_busy, a_bus.trk_start, a_ovr, a_bus.mem_re, a_bus.mem_we, a_bus.ref_mark}); else n_pass++;
    n_chk++; if ({a_bus.chk_addr, a_bus.mem_addr} !== 14'd0 || a_bus.mem_wdata !== 32'd0)
      $display("FAIL rmid_bus: got addr=%h wdata=%h expected 0/0", {a_bus.chk_addr, a_bus.mem_addr}, a_bus.mem_wdata); else n_pass++;
    @(posedge clk);
    #1 rst = 1'b0;
    wait_until(cyc + 6);
    n_chk++; if (a_pc !== 16'd0 || a_busy !== 1'b0 || ref_n !== 0)
      $display("FAIL rmid_after: got pc=%0d busy=%b ref=%0d expected 0/0/0", a_pc, a_busy, ref_n); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic_pass();
    test_skip_rows();
    test_contention();
    test_force_refresh();
    test_overrun();
    test_reset_mid_pass();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
